vga_text_writer: RTL and testbench
==================================

// Module: vga_text_writer
// PURPOSE
//  Terminal-style character sink feeding the 64x32 text RAM that the VGA text display scans.
//  Accepts one 8-bit char per handshake, tracks a cursor, writes glyph codes into RAM.
//  Interprets LF/CR/BS/FF, clears the screen on reset, and wraps or scrolls at the bottom.
//  Sits between the CPU/UART char stream and the text RAM write port.
// PARAMETERS
//  TEXT_COLS  64     columns per text row
//  TEXT_ROWS  32     text rows
//  BLANK      8'h20  fill code used by screen/line clear
// PORTS
//  clk        in   1    single clock, all logic on posedge
//  reset_n    in   1    synchronous, active-low reset
//  ch_valid   in   1    char offered
//  ch_data    in   8    char code
//  ch_ready   out  1    block accepts ch_data this cycle
//  text_we    out  1    text RAM write enable
//  text_wa    out  11   write address = row*TEXT_COLS + col, 0-based
//  text_wd    out  8    write data
//  text_ra    out  11   read address (used only with scroll)
//  text_rd    in   8    read data, valid 1 cycle after text_ra
//  cur_col    out  6    cursor column
//  cur_row    out  5    cursor row
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): text_we=0, text_wa=0, text_ra=0, text_wd=BLANK,
//   ch_ready=0, cursor=(0,0), state<=sClear. Reset mid-sweep/scroll abandons it.
//  All outputs registered. States: sClear, sIdle, sClrLine, sScroll.
//  sClear: write BLANK to addr 0..2047, one per cycle (2048 cycles); then sIdle.
//  sIdle: ch_ready=1. Accept on ch_valid&&ch_ready; write appears next cycle.
//   0x0A LF: col=0, row advance.  0x0D CR: col=0, no write.
//   0x08 BS: col=col-1 if col>0, else no change; no erase.
//   0x0C FF: cursor=(0,0), go sClear.
//   other codes (incl. 0x00-0x1F not listed): write code at cursor, col+1;
//    col 63 -> col=0 + row advance.
//  Row advance, row<31: row+1, stay sIdle.
//  Row advance, row==31: see CONFIGURATION. ch_ready=0 from the next cycle until done.
//  sClrLine: write BLANK to 64 cells of the target row, 64 cycles, then sIdle.
//  ch_ready is 0 in every state but sIdle; no char is lost or duplicated.
//  ch_ready is registered; a char offered while ch_ready=0 is held off, not dropped.
// CONFIGURATION
//  Macro VGA_TEXT_SCROLL_EN.
//  Undefined: bottom row advance -> row=0, sClrLine on row 0. text_ra=0, text_rd ignored.
//  Defined: bottom row advance -> row stays 31, sScroll:
//   text_ra steps 64..2047, one per cycle; write text_rd to text_ra-64 one cycle later.
//   1985 cycles total, then sClrLine on row 31.
// STRUCTURE
//  Package vga_text_pkg: TEXT_COLS/ROWS, address/col/row widths (clog2),
//   control codes (LF, CR, BS, FF), state enum.
//  Sub-module text_cursor: col/row counter with inc/dec/cr/advance inputs and a
//   bottom_wrap strobe.
// TESTING
//  Reset 1 cycle low: 2048 BLANK writes to addrs 0..2047 in order, then ch_ready=1, cursor (0,0).
//  Send 'A','B' back-to-back: writes (0,0x41),(1,0x42) on consecutive cycles; cursor (2,0).
//  At col 63 row 0, send 'Z': write addr 63=0x5A; cursor (0,1). Send CR, BS: cursor (0,1), no writes.
//  No scroll, row 31, send LF: cursor (0,0); 64 BLANK writes to addr 0..63; ch_ready low 64 cycles.
//  Scroll, preload row1='x': LF at row 31 -> addr 0..63='x', addr 1984..2047=BLANK, cursor (0,31).
//  Drop reset_n mid-scroll: next cycle text_we=0, ch_ready=0; full 2048-cell clear restarts.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared geometry, control codes and FSM states for the VGA text writer.
package vga_text_pkg;

  localparam int TEXT_COLS = 64;
  localparam int TEXT_ROWS = 32;
  localparam int CELLS     = TEXT_COLS * TEXT_ROWS;
  localparam int ADDR_W    = $clog2(CELLS);
  localparam int COL_W     = $clog2(TEXT_COLS);
  localparam int ROW_W     = $clog2(TEXT_ROWS);

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_CLR_LINE,
    S_SCROLL
  } state_t;

  // Power-of-two geometry makes the linear cell address a plain concatenation.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor column/row tracker for the text writer; flags an advance off the bottom row.
// Build option VGA_TEXT_SCROLL_EN: the row stays on the bottom line instead of wrapping to 0.
module text_cursor
  import vga_text_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             home,
  input  logic             inc,
  input  logic             dec,
  input  logic             cr,
  input  logic             lf,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             bottom_wrap
);

  logic at_last_col;
  logic advance;

  assign at_last_col = (col == COL_W'(TEXT_COLS - 1));
  assign advance     = lf | (inc & at_last_col);
  assign bottom_wrap = advance & (row == ROW_W'(TEXT_ROWS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || home) begin
      col <= '0;
      row <= '0;
    end else begin
      if (lf || cr || (inc && at_last_col)) col <= '0;
      else if (inc)                         col <= col + 1'b1;
      else if (dec && col != '0)            col <= col - 1'b1;

      if (advance) begin
`ifdef VGA_TEXT_SCROLL_EN
        if (!bottom_wrap) row <= row + 1'b1;
`else
        row <= bottom_wrap ? '0 : row + 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/vga_text_writer.sv
// Terminal-style character sink driving the 64x32 text RAM write port.
// Build option VGA_TEXT_SCROLL_EN: scroll the screen up at the bottom row instead of wrapping.
//
//   state      | meaning
//   S_CLEAR    | blank all 2048 cells, one per cycle (after reset or FF)
//   S_IDLE     | ch_ready high, accept and interpret one char per cycle
//   S_CLR_LINE | blank the 64 cells of clr_row
//   S_SCROLL   | copy rows 1..31 up one row via the read port
module vga_text_writer
  import vga_text_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ch_valid,
  input  logic [7:0]        ch_data,
  output logic              ch_ready,
  output logic              text_we,
  output logic [ADDR_W-1:0] text_wa,
  output logic [7:0]        text_wd,
  output logic [ADDR_W-1:0] text_ra,
  input  logic [7:0]        text_rd,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  cur_row
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [ROW_W-1:0]  clr_row, clr_row_n;
  logic              we_n, ready_n;
  logic [ADDR_W-1:0] wa_n, ra_n;
  logic [7:0]        wd_n;

  logic accept, is_ctrl;
  logic cur_home, cur_inc, cur_dec, cur_cr, cur_lf, bottom_wrap;

  // ch_ready is only ever high in S_IDLE, so accept implies the idle state.
  assign accept   = ch_valid & ch_ready;
  assign is_ctrl  = ch_data inside {CH_LF, CH_CR, CH_BS, CH_FF};
  assign cur_lf   = accept && (ch_data == CH_LF);
  assign cur_cr   = accept && (ch_data == CH_CR);
  assign cur_dec  = accept && (ch_data == CH_BS);
  assign cur_home = accept && (ch_data == CH_FF);
  assign cur_inc  = accept && !is_ctrl;

  text_cursor u_cursor (
    .clk         (clk),
    .reset_n     (reset_n),
    .home        (cur_home),
    .inc         (cur_inc),
    .dec         (cur_dec),
    .cr          (cur_cr),
    .lf          (cur_lf),
    .col         (cur_col),
    .row         (cur_row),
    .bottom_wrap (bottom_wrap)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    clr_row_n = clr_row;
    we_n      = 1'b0;
    wa_n      = text_wa;
    wd_n      = BLANK;
    ra_n      = text_ra;
    ready_n   = 1'b0;
    case (state)
      S_CLEAR: begin
        we_n  = 1'b1;
        wa_n  = cnt;
        cnt_n = cnt + 1'b1;
        if (cnt == ADDR_W'(CELLS - 1)) begin
          state_n = S_IDLE;
          ready_n = 1'b1;
        end
      end
      S_IDLE: begin
        ready_n = 1'b1;
        if (cur_inc) begin
          we_n = 1'b1;
          wa_n = cell_addr(cur_row, cur_col);
          wd_n = ch_data;
        end
        if (cur_home) begin
          state_n = S_CLEAR;
          cnt_n   = '0;
          ready_n = 1'b0;
        end else if (bottom_wrap) begin
          cnt_n   = '0;
          ready_n = 1'b0;
`ifdef VGA_TEXT_SCROLL_EN
          state_n = S_SCROLL;
          ra_n    = ADDR_W'(TEXT_COLS);
`else
          state_n   = S_CLR_LINE;
          clr_row_n = '0;
`endif
        end
      end
      S_CLR_LINE: begin
        we_n  = 1'b1;
        wa_n  = cell_addr(clr_row, cnt[COL_W-1:0]);
        cnt_n = cnt + 1'b1;
        if (cnt[COL_W-1:0] == COL_W'(TEXT_COLS - 1)) begin
          state_n = S_IDLE;
          ready_n = 1'b1;
        end
      end
      S_SCROLL: begin
        // Read data lags the address by a cycle, so the write trails the read by one step.
        if (cnt != '0) begin
          we_n = 1'b1;
          wa_n = cnt - 1'b1;
          wd_n = text_rd;
        end
        if (cnt < ADDR_W'(CELLS - TEXT_COLS - 1)) ra_n = text_ra + 1'b1;
        cnt_n = cnt + 1'b1;
        if (cnt == ADDR_W'(CELLS - TEXT_COLS)) begin
          state_n   = S_CLR_LINE;
          clr_row_n = ROW_W'(TEXT_ROWS - 1);
          cnt_n     = '0;
        end
      end
      default: state_n = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_CLEAR;
      cnt      <= '0;
      clr_row  <= '0;
      text_we  <= 1'b0;
      text_wa  <= '0;
      text_wd  <= BLANK;
      text_ra  <= '0;
      ch_ready <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      clr_row  <= clr_row_n;
      text_we  <= we_n;
      text_wa  <= wa_n;
      text_wd  <= wd_n;
      text_ra  <= ra_n;
      ch_ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer: screen/cursor model, RAM model, write scoreboard.
// Works for both builds (VGA_TEXT_SCROLL_EN defined or not).
module tb_vga_text_writer;
  import vga_text_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        ch_ready;
  logic        text_we;
  logic [10:0] text_wa;
  logic [7:0]  text_wd;
  logic [10:0] text_ra;
  logic [7:0]  text_rd;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;

  always #5 clk = ~clk;

  vga_text_writer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .text_we  (text_we),
    .text_wa  (text_wa),
    .text_wd  (text_wd),
    .text_ra  (text_ra),
    .text_rd  (text_rd),
    .cur_col  (cur_col),
    .cur_row  (cur_row)
  );

  // Text RAM with one-cycle registered read.
  logic [7:0] ram [2048];
  always @(posedge clk) begin
    if (text_we === 1'b1) ram[text_wa] <= text_wd;
    text_rd <= ram[text_ra];
  end

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  bit model_valid = 0;

  logic [7:0] screen [2048];
  int m_col = 0, m_row = 0;
  int exp_wa[$];
  logic [7:0] exp_wd[$];
  int obs_wa[$];
  int obs_wd[$];
  int obs_t[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic push_w(input int a, input logic [7:0] d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
    screen[a] = d;
  endtask

  task automatic advance_row();
    if (m_row < 31) m_row++;
    else begin
`ifdef VGA_TEXT_SCROLL_EN
      for (int j = 0; j < 1984; j++) push_w(j, screen[j + 64]);
      for (int c = 0; c < 64; c++) push_w(1984 + c, 8'h20);
`else
      m_row = 0;
      for (int c = 0; c < 64; c++) push_w(c, 8'h20);
`endif
    end
  endtask

  task automatic model_accept(input logic [7:0] c);
    case (c)
      8'h0A: begin m_col = 0; advance_row(); end
      8'h0D: m_col = 0;
      8'h08: if (m_col > 0) m_col--;
      8'h0C: begin
        m_col = 0; m_row = 0;
        for (int i = 0; i < 2048; i++) push_w(i, 8'h20);
      end
      default: begin
        push_w(m_row * 64 + m_col, c);
        if (m_col == 63) begin m_col = 0; advance_row(); end
        else m_col++;
      end
    endcase
  endtask

  // Scoreboard: every DUT write must match the next expected write; cursor checked whenever ready.
  always @(negedge clk) begin
    cycle++;
    if (text_we === 1'b1) begin
      obs_wa.push_back(int'(text_wa));
      obs_wd.push_back(int'(text_wd));
      obs_t.push_back(cycle);
      if (exp_wa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d data %0d, want no write", text_wa, text_wd);
      end else begin
        check("write_addr", int'(text_wa), exp_wa.pop_front());
        check("write_data", int'(text_wd), int'(exp_wd.pop_front()));
      end
    end
    if (model_valid && ch_ready === 1'b1) begin
      check("cursor_col", int'(cur_col), m_col);
      check("cursor_row", int'(cur_row), m_row);
    end
  end

  task automatic send(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    ch_valid = 1'b1;
    ch_data  = c;
    while (ch_ready !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
    if (ch_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: ch_ready got %b, want 1 within 6000 cycles", ch_ready);
      ch_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      ch_valid = 1'b0;
      model_accept(c);
    end
  endtask

  task automatic wait_ready(output int low);
    low = 0;
    @(negedge clk);
    while (ch_ready !== 1'b1 && low < 6000) begin low++; @(negedge clk); end
    if (ch_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: ch_ready got %b, want 1 within 6000 cycles", ch_ready);
    end
  endtask

  task automatic drained();
    @(negedge clk);
    check("queue_drained", exp_wa.size(), 0);
  endtask

  task automatic screen_cmp(input string name);
    int m = 0;
    for (int i = 0; i < 2048; i++) if (ram[i] !== screen[i]) m++;
    check(name, m, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    ch_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_wa.delete(); exp_wd.delete();
    obs_wa.delete(); obs_wd.delete(); obs_t.delete();
    m_col = 0; m_row = 0;
    model_valid = 1;
    for (int i = 0; i < 2048; i++) push_w(i, 8'h20);
    @(negedge clk);
    check("reset_we", int'(text_we), 0);
    check("reset_ready", int'(ch_ready), 0);
    check("reset_wa", int'(text_wa), 0);
    check("reset_ra", int'(text_ra), 0);
    check("reset_wd", int'(text_wd), 32);
    check("reset_col", int'(cur_col), 0);
    check("reset_row", int'(cur_row), 0);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    int n;

    do_reset();
    wait_ready(low);
    drained();
    check("clear_count", obs_wa.size(), 2048);
    check("clear_first_addr", obs_wa[0], 0);
    check("clear_last_addr", obs_wa[2047], 2047);
    check("clear_data", obs_wd[1000], 32);
    screen_cmp("screen_after_reset");

    obs_wa.delete(); obs_wd.delete(); obs_t.delete();
    send(8'h41);
    send(8'h42);
    wait_ready(low);
    drained();
    check("ab_addr0", obs_wa[0], 0);
    check("ab_data0", obs_wd[0], 65);
    check("ab_addr1", obs_wa[1], 1);
    check("ab_data1", obs_wd[1], 66);
    check("ab_back_to_back", obs_t[1] - obs_t[0], 1);
    check("ab_col", int'(cur_col), 2);
    check("ab_row", int'(cur_row), 0);

    for (int i = 0; i < 61; i++) send(8'(97 + i % 26));
    send(8'h5A);
    wait_ready(low);
    drained();
    check("z_addr", obs_wa[obs_wa.size() - 1], 63);
    check("z_data", obs_wd[obs_wd.size() - 1], 90);
    check("z_col", int'(cur_col), 0);
    check("z_row", int'(cur_row), 1);

    n = obs_wa.size();
    send(8'h0D);
    send(8'h08);
    wait_ready(low);
    drained();
    check("cr_bs_no_write", obs_wa.size(), n);
    check("cr_bs_col", int'(cur_col), 0);
    check("cr_bs_row", int'(cur_row), 1);

    send(8'h01);
    wait_ready(low);
    drained();
    check("ctrl01_addr", obs_wa[obs_wa.size() - 1], 64);
    check("ctrl01_data", obs_wd[obs_wd.size() - 1], 1);
    check("ctrl01_col", int'(cur_col), 1);

    send(8'h0D);
    for (int i = 0; i < 64; i++) send(8'h78);
    while (m_row < 31) send(8'h0A);
    wait_ready(low);
    drained();
    check("at_bottom_row", int'(cur_row), 31);

    send(8'h0A);
    wait_ready(low);
    drained();
`ifdef VGA_TEXT_SCROLL_EN
    check("bottom_lf_busy_cycles", low, 2049);
    check("bottom_lf_row", int'(cur_row), 31);
    check("scroll_row0", int'(ram[0]), 120);
    check("scroll_row31", int'(ram[2047]), 32);
`else
    check("bottom_lf_busy_cycles", low, 64);
    check("bottom_lf_row", int'(cur_row), 0);
    check("wrap_row0", int'(ram[0]), 32);
    check("wrap_row1", int'(ram[64]), 120);
`endif
    check("bottom_lf_col", int'(cur_col), 0);
    screen_cmp("screen_after_bottom_lf");

    while (m_row < 31) send(8'h0A);
    while (m_col < 63) send(8'h77);
    send(8'h79);
    wait_ready(low);
    drained();
`ifdef VGA_TEXT_SCROLL_EN
    check("corner_char_scrolled", int'(ram[1983]), 121);
    check("corner_row", int'(cur_row), 31);
`else
    check("corner_char", int'(ram[2047]), 121);
    check("corner_row", int'(cur_row), 0);
`endif
    screen_cmp("screen_after_corner");

    send(8'h0C);
    send(8'h48);
    wait_ready(low);
    drained();
    check("ff_held_char", int'(ram[0]), 72);
    check("ff_col", int'(cur_col), 1);
    check("ff_row", int'(cur_row), 0);
    screen_cmp("screen_after_ff");

    while (m_row < 31) send(8'h0A);
    send(8'h0A);
    repeat (30) @(negedge clk);
    do_reset();
    wait_ready(low);
    drained();
    check("midop_reset_clear_count", obs_wa.size(), 2048);
    screen_cmp("screen_after_midop_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
